modport_reg_file: RTL and testbench
===================================

// Module: modport_reg_file
// PURPOSE
// - AXI4-Lite slave register file: NUM_REGS general-purpose 32-bit R/W registers,
//   one read-only status register and one R/W control register.
// - Sits on a peripheral AXI4-Lite bus as a simple CSR block; fixed OKAY responses, byte strobes honoured.
// PARAMETERS
// - NUM_REGS  4  number of general-purpose registers (1..14); GP reg n at byte offset 4*n
// PORTS
// - clk        in   1   single clock, all logic on rising edge
// - rst        in   1   reset, asynchronous, active-high
// - s_awaddr   in   32  write address; only [7:0] decoded
// - s_awprot   in   3   ignored
// - s_awvalid  in   1   / s_awready out 1 : AW handshake
// - s_wdata    in   32  write data
// - s_wstrb    in   4   byte strobes, bit k enables byte [8k+7:8k]
// - s_wvalid   in   1   / s_wready out 1 : W handshake
// - s_bresp    out  2   write response
// - s_bvalid   out  1   / s_bready in 1 : B handshake
// - s_araddr   in   32  read address; only [7:0] decoded
// - s_arprot   in   3   ignored
// - s_arvalid  in   1   / s_arready out 1 : AR handshake
// - s_rdata    out  32  read data
// - s_rresp    out  2   read response
// - s_rvalid   out  1   / s_rready in 1 : R handshake
// - Interface: one clock; reset is asynchronous and active-high.
// BEHAVIOUR
// - Map (addr[7:0]): 0x00..4*(NUM_REGS-1) GP regs; STATUS=4*NUM_REGS (RO); CONTROL=4*NUM_REGS+4 (R/W); other = unmapped.
// - Reset: all GP, CONTROL, STATUS = 0; awready/wready/arready = 1; bvalid/rvalid = 0; bresp/rresp/rdata = 0.
// - Write path: AW and W captured independently into one-entry holding regs (aw_full, w_full).
//   s_awready = !aw_full && !s_bvalid; s_wready = !w_full && !s_bvalid. Either order / same cycle legal.
// - Commit: on the edge where aw_full && w_full: update target bytes per wstrb, clear both full flags,
//   assert s_bvalid with bresp=2'b00. AW+W in same cycle -> bvalid 2 cycles later.
// - s_bvalid held (bresp stable) until s_bvalid && s_bready; no new AW/W accepted while bvalid high.
// - Writes to STATUS or unmapped address: no state change, response still issued.
// - Read path: s_arready = !s_rvalid. On AR handshake edge, rdata latched from current register
//   values (pre-commit value if a write commits on the same edge), s_rvalid=1 next cycle (1-cycle latency).
// - s_rvalid/rdata/rresp held until s_rvalid && s_rready; back-to-back reads every 2 cycles max when rready=1.
// - Unmapped read returns 32'h0.
// - STATUS: [0]=0 (reset flag, always 0 out of reset); [1]=1 for exactly one cycle after each write commit;
//   [2]=1 for exactly one cycle after each AR handshake; [31:3]=0.
// - Read and write channels operate concurrently and independently.
// - Reset asserted mid-transaction: all pending AW/W/AR/B/R discarded, registers cleared immediately.
// CONFIGURATION
// - SLVERR_RESP_EN defined: access to unmapped address returns bresp/rresp = 2'b10 (SLVERR); write to
//   STATUS also returns SLVERR. Register state unaffected as without the macro.
// - SLVERR_RESP_EN undefined: all responses 2'b00 (OKAY).
// TESTING
// - Reset: after rst deassert, read 0x00,0x04,0x08,0x0C,0x14 -> all 32'h0, rresp=00; arready=1.
// - Write 0x04=32'hDEADBEEF wstrb=4'hF, then read 0x04 -> 32'hDEADBEEF; bvalid 2 cycles after AW+W.
// - Partial strobe: 0x08=32'h11223344 full, then 32'hAABBCCDD wstrb=4'b0101 -> read 0x08 = 32'h11BB33DD.
// - AW 3 cycles before W, bready low 5 cycles: awready low while aw_full; bvalid/bresp held; no 2nd write accepted.
// - Write 0x10=32'hFFFFFFFF then read 0x10 -> bits[31:3]=0; read 0x40 -> 32'h0, rresp=00 (10 with SLVERR_RESP_EN).
// - rready low 4 cycles on read of 0x14: rvalid/rdata stable, arready=0 until R handshake completes.

Source files
------------

// File: rtl/modport_reg_file.sv
// rtl/modport_reg_file.sv - AXI4-Lite CSR block: NUM_REGS GP regs, RO STATUS, R/W CONTROL
// Optional: define SLVERR_RESP_EN to answer unmapped/STATUS-write accesses with SLVERR.
module modport_reg_file #(
    parameter int NUM_REGS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready
);

    localparam logic [5:0] STATUS_IDX  = 6'(NUM_REGS);
    localparam logic [5:0] CONTROL_IDX = 6'(NUM_REGS + 1);

    logic        aw_full;
    logic        w_full;
    logic [5:0]  aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] gp [NUM_REGS];
    logic [31:0] control;
    logic        wr_pulse;
    logic        rd_pulse;
    logic        commit;
    logic        ar_hs;
    logic [5:0]  ar_idx;
    logic [31:0] status_val;
    logic [31:0] rd_val;
    logic [1:0]  wr_resp;
    logic [1:0]  rd_resp;
    logic        unused_ok;

    assign s_awready  = !aw_full && !s_bvalid;
    assign s_wready   = !w_full && !s_bvalid;
    assign s_arready  = !s_rvalid;
    assign commit     = aw_full && w_full;
    assign ar_hs      = s_arvalid && s_arready;
    assign ar_idx     = s_araddr[7:2];
    assign status_val = {29'b0, rd_pulse, wr_pulse, 1'b0};
    assign unused_ok  = ^{s_awprot, s_arprot, s_awaddr[31:8], s_awaddr[1:0],
                          s_araddr[31:8], s_araddr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Unmapped reads fall through to the zero default.
    always_comb begin
        rd_val = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == 6'(i)) rd_val = gp[i];
        end
        if (ar_idx == STATUS_IDX)  rd_val = status_val;
        if (ar_idx == CONTROL_IDX) rd_val = control;
    end

`ifdef SLVERR_RESP_EN
    assign wr_resp = (aw_idx > CONTROL_IDX || aw_idx == STATUS_IDX) ? 2'b10 : 2'b00;
    assign rd_resp = (ar_idx > CONTROL_IDX) ? 2'b10 : 2'b00;
`else
    assign wr_resp = 2'b00;
    assign rd_resp = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx   <= 6'h0;
            w_data   <= 32'h0;
            w_strb   <= 4'h0;
            for (int i = 0; i < NUM_REGS; i++) gp[i] <= 32'h0;
            control  <= 32'h0;
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            s_rvalid <= 1'b0;
            s_rdata  <= 32'h0;
            s_rresp  <= 2'b00;
        end else begin
            wr_pulse <= commit;
            rd_pulse <= ar_hs;

            if (s_awvalid && s_awready) begin
                aw_full <= 1'b1;
                aw_idx  <= s_awaddr[7:2];
            end
            if (s_wvalid && s_wready) begin
                w_full <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end

            // Holding regs cannot refill while bvalid is up, so commit and B handshake never collide.
            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_idx == 6'(i)) gp[i] <= merge_bytes(gp[i], w_data, w_strb);
                end
                if (aw_idx == CONTROL_IDX) control <= merge_bytes(control, w_data, w_strb);
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_val;
                s_rresp  <= rd_resp;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modport_reg_file.sv
// tb/tb_modport_reg_file.sv - directed self-checking bench for modport_reg_file
module tb_modport_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic [2:0]  s_awprot = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [2:0]  s_arprot = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int errors = 0;
    int checks = 0;

`ifdef SLVERR_RESP_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    modport_reg_file #(.NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, output int lat);
        int n;
        int c;
        logic aw_hs;
        logic w_hs;
        @(negedge clk);
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        s_bready = 1'b1;
        n = 0;
        while ((s_awvalid || s_wvalid) && n < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk);
            n++;
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid = 1'b0;
        end
        if (s_awvalid || s_wvalid) check("wr_accept_timeout", 32'(n), 32'(-1));
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        c = 0;
        while (!s_bvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        lat = n + c;
        check("wr_bvalid", 32'(s_bvalid), 32'd1);
        check("wr_bresp", 32'(s_bresp), 32'(exp_resp));
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        logic hs;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        while (s_arvalid && n < 20) begin
            hs = s_arready;
            @(negedge clk);
            n++;
            if (hs) s_arvalid = 1'b0;
        end
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_rvalid", 32'(s_rvalid), 32'd1);
        d = s_rdata;
        r = s_rresp;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int          lat;
        logic [31:0] reset_addrs [5];
        reset_addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_awready", 32'(s_awready), 32'd1);
        check("rst_wready", 32'(s_wready), 32'd1);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            axi_read(reset_addrs[i], rd, rr);
            check($sformatf("rst_rd_%0h", reset_addrs[i]), rd, 32'h0);
            check("rst_rresp", 32'(rr), 32'd0);
        end

        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00, lat);
        check("wr_latency", 32'(lat), 32'd2);
        axi_read(32'h04, rd, rr);
        check("rd_04", rd, 32'hDEADBEEF);

        axi_write(32'h08, 32'h11223344, 4'hF, 2'b00, lat);
        axi_write(32'h08, 32'hAABBCCDD, 4'b0101, 2'b00, lat);
        axi_read(32'h08, rd, rr);
        check("rd_08_strb", rd, 32'h11BB33DD);
        axi_write(32'h00, 32'h0000A500, 4'b0010, 2'b00, lat);
        axi_read(32'h00, rd, rr);
        check("rd_00_strb", rd, 32'h0000A500);

        // AW three cycles ahead of W, bready held low for five cycles
        @(negedge clk);
        s_awaddr = 32'h0C; s_awvalid = 1'b1; s_bready = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b0;
        check("aw_full_awready", 32'(s_awready), 32'd0);
        @(negedge clk);
        check("aw_full_awready2", 32'(s_awready), 32'd0);
        check("aw_full_wready", 32'(s_wready), 32'd1);
        @(negedge clk);
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        check("pre_commit_bvalid", 32'(s_bvalid), 32'd0);
        @(negedge clk);
        check("commit_bvalid", 32'(s_bvalid), 32'd1);
        s_awaddr = 32'h0C; s_awvalid = 1'b1;
        s_wdata = 32'h99999999; s_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", 32'(s_bvalid), 32'd1);
            check("hold_bresp", 32'(s_bresp), 32'd0);
            check("hold_awready", 32'(s_awready), 32'd0);
            check("hold_wready", 32'(s_wready), 32'd0);
            @(negedge clk);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        check("b_done_bvalid", 32'(s_bvalid), 32'd0);
        axi_read(32'h0C, rd, rr);
        check("rd_0C_no_2nd", rd, 32'h12345678);

        axi_write(32'h10, 32'hFFFFFFFF, 4'hF, ERR_RESP, lat);
        axi_read(32'h10, rd, rr);
        check("rd_status_idle", rd, 32'h0);
        axi_read(32'h40, rd, rr);
        check("rd_unmapped", rd, 32'h0);
        check("rd_unmapped_resp", 32'(rr), 32'(ERR_RESP));

        // AR lands on the edge right after a commit: STATUS[1] visible
        @(negedge clk);
        s_awaddr = 32'h14; s_awvalid = 1'b1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        check("st_bvalid", 32'(s_bvalid), 32'd1);
        s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_arvalid = 1'b0; s_bready = 1'b0;
        check("st_rvalid", 32'(s_rvalid), 32'd1);
        check("st_wr_pulse", s_rdata, 32'h2);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;

        // rready low four cycles on CONTROL read
        @(negedge clk);
        s_araddr = 32'h14; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'hCAFEF00D);
            check("stall_arready", 32'(s_arready), 32'd0);
            @(negedge clk);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check("r_done_rvalid", 32'(s_rvalid), 32'd0);
        check("r_done_arready", 32'(s_arready), 32'd1);

        // reset asserted with an AW pending
        @(negedge clk);
        s_awaddr = 32'h04; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        check("mid_awready_busy", 32'(s_awready), 32'd0);
        #2 rst = 1'b1;
        #1 check("mid_rst_awready", 32'(s_awready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        axi_read(32'h04, rd, rr);
        check("mid_rst_rd_04", rd, 32'h0);
        axi_read(32'h14, rd, rr);
        check("mid_rst_rd_ctrl", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
